chip_6502_bus_seq: RTL and testbench
====================================

Name: chip_6502_bus_seq

Overview:
Phase sequencer and bus interface for the node-level 6502 netlist core. The core needs several FPGA clocks of node settling per clock level, so this block generates the core's phi and its reset-release sequence. It presents each CPU bus cycle to system memory as a stallable valid/ready transaction and feeds read data back into the core. It sits between the netlist core and the memory/IO fabric; settle time, widths and reset length are parameters.

Parameters:
SETTLE, 4, clk cycles per phi half-phase segment (>=1)
RESET_PHASES, 8, full phi cycles core_res is held low after external res deasserts (>=1)
ADDR_W, 16, address bus width
DATA_W, 8, data bus width
CNT_W, 32, width of CPU cycle counter

Ports:
clk  in  1  FPGA clock, all logic on rising edge
res  in  1  asynchronous active-low reset
core_phi  out  1  phi drive to netlist core (clk0 node)
core_res  out  1  active-low reset drive to netlist core
core_ab  in  ADDR_W  core address bus
core_rw  in  1  core rw (1 = read)
core_dbo  in  DATA_W  core data out
core_sync  in  1  core sync (opcode fetch)
core_dbi  out  DATA_W  registered data in to core
mem_req  out  1  transaction valid
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  transaction address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data, valid with mem_ready
mem_ready  in  1  transaction accept/complete
cpu_cycles  out  CNT_W  completed CPU bus cycles since core reset release
sync_pulse  out  1  one-clk pulse when an opcode-fetch transaction is issued

Behaviour:
- res low (async): state=RST; core_phi=0, core_res=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, core_dbi=0, cpu_cycles=0, sync_pulse=0; phase counter cleared; reset-phase counter = RESET_PHASES.
- First clk with res high: RST -> PH1.
- States:
  - PH1: core_phi=0.
  - PH2A: core_phi=1, pre-request settle.
  - WAIT: core_phi=1, mem_req high.
  - PH2B: core_phi=1, post-data settle.
- PH1, PH2A and PH2B each last exactly SETTLE clks (counter 0..SETTLE-1, cleared on every state change).
- PH1 -> PH2A.
- PH2A last clk, core_res=1 (running):
  - register mem_addr=core_ab, mem_we=~core_rw, mem_wdata=core_dbo;
  - mem_req=1 and sync_pulse=core_sync, both effective on entry to WAIT;
  - next state WAIT.
- PH2A last clk, core_res=0: no transaction; go directly to PH2B.
- WAIT: mem_req, mem_addr, mem_we, mem_wdata held stable until the clk where mem_ready=1. At that clk:
  - read: core_dbi <= mem_rdata; write: core_dbi unchanged;
  - mem_req drops next clk; next state PH2B.
  - Unbounded stall: phi stays high.
  - mem_ready while mem_req=0 is ignored.
- PH2B last clk -> PH1. If core_res=1, cpu_cycles increments (wraps at 2^CNT_W).
- Reset release: each PH2B->PH1 transition with core_res=0 decrements the reset-phase counter. When it reaches 0, core_res=1 from that PH1 entry onward. The first transaction occurs in the following PH2A.
- Phi period: 3*SETTLE+1+w clks, where w = extra WAIT clks beyond the first. Period is 3*SETTLE during reset phases.
- sync_pulse is high for exactly one clk per fetch, coincident with the first mem_req clk.
- Async res asserted mid-transaction (including WAIT): mem_req drops immediately and all outputs return to reset values; no completion is reported.
- core_dbi only changes in WAIT, so it is stable through all of PH2B and the phi falling edge.

Test Plan:
1. Reset sequence (SETTLE=4, RESET_PHASES=8): deassert res -> core_phi toggles with 4-low/8-high clk pattern; core_res rises at the 9th PH1 entry (96 clks after release); no mem_req before then; cpu_cycles=0.
2. Zero-wait read: core_ab=16'hFFFC, core_rw=1, mem_ready tied 1, mem_rdata=8'h00 -> mem_req high exactly 1 clk with mem_addr=FFFC, mem_we=0; core_dbi=00 through PH2B; phi period 13 clks; cpu_cycles increments by 1.
3. Stalled read: mem_ready low 3 clks, then high with mem_rdata=8'hA9 -> mem_req high 4 clks with stable address; phi high 4+4+4=12 clks; core_dbi=A9 applied before phi falls.
4. Write: core_rw=0, core_ab=16'h0200, core_dbo=8'h5A -> mem_we=1, mem_addr=0200, mem_wdata=5A held until ready; core_dbi unchanged.
5. Sync: core_sync=1 at end of PH2A -> sync_pulse one clk coincident with mem_req rise; core_sync=0 cycle -> no pulse.
6. Async reset in WAIT (mem_ready held low): drop res -> mem_req=0, core_phi=0, core_res=0, cpu_cycles=0 in the same clk; full RESET_PHASES sequence repeats after release.

Source files
------------

// File: rtl/chip_6502_bus_seq.sv
// Phi/reset sequencer and valid/ready bus bridge for the node-level 6502 netlist core.
// Each phi cycle is PH1 (low), then PH2A, WAIT and PH2B (high). A bus transaction is issued only once the core is out of reset.
module chip_6502_bus_seq #(
  parameter int SETTLE       = 4,
  parameter int RESET_PHASES = 8,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              res,
  output logic              core_phi,
  output logic              core_res,
  input  logic [ADDR_W-1:0] core_ab,
  input  logic              core_rw,
  input  logic [DATA_W-1:0] core_dbo,
  input  logic              core_sync,
  output logic [DATA_W-1:0] core_dbi,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  cpu_cycles,
  output logic              sync_pulse
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int RW = $clog2(RESET_PHASES + 1);
  localparam logic [SW-1:0] SEG_LAST = SW'(SETTLE - 1);
  localparam logic [RW-1:0] RPH_INIT = RW'(RESET_PHASES);

  typedef enum logic [2:0] {
    ST_RST,
    ST_PH1,
    ST_PH2A,
    ST_WAIT,
    ST_PH2B
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     rph_q, rph_d;
  logic              core_phi_q, core_phi_d;
  logic              core_res_q, core_res_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] core_dbi_q, core_dbi_d;
  logic [CNT_W-1:0]  cpu_cycles_q, cpu_cycles_d;
  logic              sync_pulse_q, sync_pulse_d;
  logic              seg_last;

  always_comb begin
    state_d      = state_q;
    rph_d        = rph_q;
    core_res_d   = core_res_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    core_dbi_d   = core_dbi_q;
    cpu_cycles_d = cpu_cycles_q;
    sync_pulse_d = 1'b0;
    seg_last     = (cnt_q == SEG_LAST);

    case (state_q)
      ST_RST: state_d = ST_PH1;
      ST_PH1: if (seg_last) state_d = ST_PH2A;
      ST_PH2A: begin
        if (seg_last) begin
          if (core_res_q) begin
            mem_addr_d   = core_ab;
            mem_we_d     = ~core_rw;
            mem_wdata_d  = core_dbo;
            mem_req_d    = 1'b1;
            sync_pulse_d = core_sync;
            state_d      = ST_WAIT;
          end else begin
            state_d = ST_PH2B;
          end
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) core_dbi_d = mem_rdata;
          state_d = ST_PH2B;
        end
      end
      ST_PH2B: begin
        if (seg_last) begin
          state_d = ST_PH1;
          if (core_res_q) begin
            cpu_cycles_d = cpu_cycles_q + CNT_W'(1);
          end else begin
            rph_d = rph_q - RW'(1);
            if (rph_q == RW'(1)) core_res_d = 1'b1;
          end
        end
      end
      default: state_d = ST_RST;
    endcase

    // WAIT holds the segment counter at zero so PH2B always gets a full SETTLE count.
    cnt_d      = (state_d != state_q || state_q == ST_WAIT) ? '0 : cnt_q + SW'(1);
    core_phi_d = (state_d == ST_PH2A) || (state_d == ST_WAIT) || (state_d == ST_PH2B);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q      <= ST_RST;
      cnt_q        <= '0;
      rph_q        <= RPH_INIT;
      core_phi_q   <= 1'b0;
      core_res_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_dbi_q   <= '0;
      cpu_cycles_q <= '0;
      sync_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rph_q        <= rph_d;
      core_phi_q   <= core_phi_d;
      core_res_q   <= core_res_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_dbi_q   <= core_dbi_d;
      cpu_cycles_q <= cpu_cycles_d;
      sync_pulse_q <= sync_pulse_d;
    end
  end

  assign core_phi   = core_phi_q;
  assign core_res   = core_res_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_dbi   = core_dbi_q;
  assign cpu_cycles = cpu_cycles_q;
  assign sync_pulse = sync_pulse_q;

endmodule

// File: tb/tb_chip_6502_bus_seq.sv
// Self-checking bench for chip_6502_bus_seq: reset-release timing, table-driven bus cycles,
// randomized bus cycles against a cycle-level model, and async reset during a stalled transaction.
module tb_chip_6502_bus_seq;

  localparam int S  = 4;
  localparam int RP = 8;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        core_phi, core_res;
  logic [15:0] core_ab = '0;
  logic        core_rw = 1'b1;
  logic [7:0]  core_dbo = '0;
  logic        core_sync = 1'b0;
  logic [7:0]  core_dbi;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] cpu_cycles;
  logic        sync_pulse;

  always #5 clk = ~clk;

  chip_6502_bus_seq #(
    .SETTLE(S),
    .RESET_PHASES(RP),
    .ADDR_W(16),
    .DATA_W(8),
    .CNT_W(32)
  ) dut (
    .clk(clk), .res(res),
    .core_phi(core_phi), .core_res(core_res),
    .core_ab(core_ab), .core_rw(core_rw), .core_dbo(core_dbo), .core_sync(core_sync),
    .core_dbi(core_dbi),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .cpu_cycles(cpu_cycles), .sync_pulse(sync_pulse)
  );

  typedef struct {
    logic [15:0] ab;
    logic        rw;
    logic [7:0]  dbo;
    logic        sync;
    int unsigned w;
    logic [7:0]  rdata;
    logic [7:0]  exp_dbi;
    int unsigned exp_hi;
  } vec_t;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [7:0]  model_dbi;
  logic [31:0] model_cycles;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Caller leaves res low; releases at a negedge and checks the phi pattern until core_res rises.
  task automatic release_seq();
    int unsigned t, run, rises, runbad, reqseen;
    logic prev;
    @(negedge clk);
    res = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("first_ph1_phi", core_phi, 1'b0);
    t = 0; run = 1; rises = 0; runbad = 0; reqseen = 0; prev = core_phi;
    while (!core_res && t < 300) begin
      @(negedge clk);
      t++;
      if (mem_req || sync_pulse) reqseen++;
      if (core_phi != prev) begin
        if (!prev && run != S) runbad++;
        if (prev && run != 2 * S) runbad++;
        if (!prev) rises++;
        run = 1;
        prev = core_phi;
      end else begin
        run++;
      end
    end
    chk("core_res_release_clks", t, 96);
    chk("reset_phi_rises", rises, RP);
    chk("reset_phi_runs_bad", runbad, 0);
    chk("reset_no_req", reqseen, 0);
    chk("reset_cycles_zero", cpu_cycles, 0);
    chk("release_phi_low", core_phi, 1'b0);
    model_dbi = 8'h00;
    model_cycles = 0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_phi"}, core_phi, 1'b0);
    chk({tag, "_core_res"}, core_res, 1'b0);
    chk({tag, "_mem_req"}, mem_req, 1'b0);
    chk({tag, "_mem_we"}, mem_we, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 16'h0000);
    chk({tag, "_mem_wdata"}, mem_wdata, 8'h00);
    chk({tag, "_core_dbi"}, core_dbi, 8'h00);
    chk({tag, "_cycles"}, cpu_cycles, 0);
    chk({tag, "_sync"}, sync_pulse, 1'b0);
  endtask

  // Called at the negedge of the first PH1 clk; returns at the first PH1 clk of the next phi cycle.
  task automatic run_cycle(input vec_t v);
    int unsigned lo, hi, reqn, stray, bad, ph2b_bad;
    logic sync_first;
    bit in_high, done;
    core_ab = v.ab; core_rw = v.rw; core_dbo = v.dbo; core_sync = v.sync;
    mem_rdata = v.rdata;
    mem_ready = 1'($urandom_range(0, 1));
    lo = 1; hi = 0; reqn = 0; stray = 0; bad = 0; ph2b_bad = 0;
    sync_first = 1'b0; in_high = 0; done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!in_high && core_phi) in_high = 1;
      if (in_high && !core_phi) begin
        done = 1;
      end else begin
        if (core_phi) hi++; else lo++;
        if (mem_req) begin
          if (mem_addr !== v.ab || mem_we !== ~v.rw || mem_wdata !== v.dbo) bad++;
          if (reqn == 0) sync_first = sync_pulse;
          else if (sync_pulse) stray++;
          mem_ready = (reqn == v.w);
          reqn++;
        end else begin
          if (sync_pulse) stray++;
          if (in_high && reqn > 0 && core_dbi !== v.exp_dbi) ph2b_bad++;
          mem_ready = 1'($urandom_range(0, 1));
        end
      end
    end
    model_cycles = model_cycles + 1;
    model_dbi = v.exp_dbi;
    chk("cycle_timeout", done, 1'b1);
    chk("phi_low_clks", lo, S);
    chk("phi_high_clks", hi, v.exp_hi);
    chk("mem_req_clks", reqn, v.w + 1);
    chk("sync_first", sync_first, v.sync);
    chk("sync_stray", stray, 0);
    chk("bus_stable", bad, 0);
    chk("dbi_ph2b_stable", ph2b_bad, 0);
    chk("core_dbi", core_dbi, v.exp_dbi);
    chk("cpu_cycles", cpu_cycles, model_cycles);
  endtask

  task automatic run_random(input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.ab      = 16'($urandom);
      v.rw      = 1'($urandom_range(0, 1));
      v.dbo     = 8'($urandom);
      v.sync    = 1'($urandom_range(0, 1));
      v.w       = $urandom_range(0, 5);
      v.rdata   = 8'($urandom);
      v.exp_dbi = v.rw ? v.rdata : model_dbi;
      v.exp_hi  = 2 * S + 1 + v.w;
      run_cycle(v);
    end
  endtask

  vec_t tbl[6];
  int unsigned found;

  initial begin
    tbl[0] = '{16'hFFFC, 1'b1, 8'h00, 1'b0, 0, 8'h00, 8'h00, 9};
    tbl[1] = '{16'h0300, 1'b1, 8'h33, 1'b0, 3, 8'hA9, 8'hA9, 12};
    tbl[2] = '{16'h0200, 1'b0, 8'h5A, 1'b0, 2, 8'h77, 8'hA9, 11};
    tbl[3] = '{16'h8000, 1'b1, 8'h00, 1'b1, 0, 8'hEA, 8'hEA, 9};
    tbl[4] = '{16'h8001, 1'b1, 8'h00, 1'b0, 1, 8'h3C, 8'h3C, 10};
    tbl[5] = '{16'h01FF, 1'b0, 8'hC3, 1'b1, 0, 8'h11, 8'h3C, 9};

    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    release_seq();

    for (int i = 0; i < 6; i++) run_cycle(tbl[i]);
    run_random(30);

    core_ab = 16'h1234; core_rw = 1'b1; core_sync = 1'b1; mem_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      @(negedge clk);
      if (mem_req) found = 1;
    end
    chk("wait_entered", found, 1);
    repeat (2) @(negedge clk);
    chk("stall_req_held", mem_req, 1'b1);
    chk("stall_addr_held", mem_addr, 16'h1234);
    #2 res = 1'b0;
    #1;
    check_reset_values("async");
    repeat (2) @(negedge clk);
    check_reset_values("async_hold");
    release_seq();
    run_random(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
